// File: rtl/ah_snoop_credit_fifo.sv
// Credit-flow FIFO with occupancy-qualified masked snoop lookup.
// Optional snoop-kill of queued entries: define AH_SNOOP_FIFO_SNOOP_KILL_EN.
module ah_snoop_credit_fifo #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEPTH      = 10,
   parameter int unsigned RD_CREDITS = 16
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       wr_valid,
   output logic                       wr_credit,
   output logic                       wr_overflow,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       rd_valid,
   input  logic                       rd_credit,
   output logic                       rd_credit_err,
   input  logic [WIDTH-1:0]           snoop_data,
   input  logic [WIDTH-1:0]           snoop_mask,
   input  logic                       snoop_valid,
   input  logic                       snoop_kill,
   output logic                       snoop_match_valid,
   output logic                       snoop_match,
   output logic [$clog2(DEPTH+1)-1:0] snoop_hit_cnt
);

   localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam int unsigned CRW = $clog2(RD_CREDITS + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CRW-1:0]   cred_q, cred_d;
   logic             cred_err_c;

   logic             head_live_c, pop_c, discard_c, deq_c, push_c;
   logic [DEPTH-1:0] live_c, occ_c, hit_c;
   logic [CW-1:0]    hit_cnt_c, off_c;

   logic             wr_credit_q, wr_overflow_q, rd_valid_q, rd_credit_err_q;
   logic [WIDTH-1:0] rd_data_q;
   logic             snoop_mv_q, snoop_match_q;
   logic [CW-1:0]    snoop_cnt_q;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

`ifdef AH_SNOOP_FIFO_SNOOP_KILL_EN
   logic [DEPTH-1:0] live_q, live_d;

   assign live_c = live_q;

   // Kill clears hits first; the entry pushed this cycle is never a hit.
   always_comb begin
      live_d = live_q;
      if (snoop_valid && snoop_kill) live_d = live_q & ~hit_c;
      if (push_c) live_d[wr_ptr_q] = 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) live_q <= '0;
      else       live_q <= live_d;
   end
`else
   logic unused_snoop_kill;

   assign live_c            = '1;
   assign unused_snoop_kill = snoop_kill;
`endif

   // Pop/discard/push decisions and next-state pointers, count, credits.
   always_comb begin
      head_live_c = live_c[rd_ptr_q];
      pop_c       = (count_q != '0) && head_live_c && (cred_q != '0);
      discard_c   = (count_q != '0) && !head_live_c;
      deq_c       = pop_c || discard_c;
      push_c      = wr_valid && ((count_q != CW'(DEPTH)) || deq_c);
      count_d     = count_q + CW'(push_c) - CW'(deq_c);
      wr_ptr_d    = push_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d    = deq_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      cred_d      = cred_q;
      cred_err_c  = 1'b0;
      if (pop_c && !rd_credit) begin
         cred_d = cred_q - CRW'(1);
      end else if (rd_credit && !pop_c) begin
         if (cred_q == CRW'(RD_CREDITS)) cred_err_c = 1'b1;
         else                            cred_d     = cred_q + CRW'(1);
      end
   end

   // Snoop compare over entries occupied at the start of the cycle.
   always_comb begin
      occ_c     = '0;
      hit_c     = '0;
      hit_cnt_c = '0;
      off_c     = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (PW'(i) >= rd_ptr_q) off_c = CW'(PW'(i) - rd_ptr_q);
         else                    off_c = CW'(i) + CW'(DEPTH) - CW'(rd_ptr_q);
         occ_c[i]  = off_c < count_q;
         hit_c[i]  = occ_c[i] && live_c[i] &&
                     (((mem_q[i] ^ snoop_data) & snoop_mask) == '0);
         hit_cnt_c = hit_cnt_c + CW'(hit_c[i]);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         cred_q          <= CRW'(RD_CREDITS);
         wr_credit_q     <= 1'b0;
         wr_overflow_q   <= 1'b0;
         rd_valid_q      <= 1'b0;
         rd_data_q       <= '0;
         rd_credit_err_q <= 1'b0;
         snoop_mv_q      <= 1'b0;
         snoop_match_q   <= 1'b0;
         snoop_cnt_q     <= '0;
      end else begin
         if (push_c) mem_q[wr_ptr_q] <= wr_data;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cred_q      <= cred_d;
         wr_credit_q <= deq_c;
         rd_valid_q  <= pop_c;
         if (pop_c) rd_data_q <= mem_q[rd_ptr_q];
         if (wr_valid && !push_c) wr_overflow_q <= 1'b1;
         if (cred_err_c) rd_credit_err_q <= 1'b1;
         snoop_mv_q    <= snoop_valid;
         snoop_match_q <= snoop_valid && (hit_c != '0);
         snoop_cnt_q   <= snoop_valid ? hit_cnt_c : '0;
      end
   end

   assign wr_credit         = wr_credit_q;
   assign wr_overflow       = wr_overflow_q;
   assign rd_data           = rd_data_q;
   assign rd_valid          = rd_valid_q;
   assign rd_credit_err     = rd_credit_err_q;
   assign snoop_match_valid = snoop_mv_q;
   assign snoop_match       = snoop_match_q;
   assign snoop_hit_cnt     = snoop_cnt_q;

endmodule

// File: tb/tb_ah_snoop_credit_fifo.sv
// Directed bench for ah_snoop_credit_fifo (default WIDTH=8, DEPTH=10, RD_CREDITS=16).
module tb_ah_snoop_credit_fifo;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 10;
   localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef AH_SNOOP_FIFO_SNOOP_KILL_EN
   localparam bit KILL = 1'b1;
`else
   localparam bit KILL = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic [WIDTH-1:0] wr_data = '0;
   logic             wr_valid = 1'b0;
   logic             wr_credit, wr_overflow, rd_valid, rd_credit_err;
   logic [WIDTH-1:0] rd_data;
   logic             rd_credit = 1'b0;
   logic [WIDTH-1:0] snoop_data = '0;
   logic [WIDTH-1:0] snoop_mask = '0;
   logic             snoop_valid = 1'b0;
   logic             snoop_kill = 1'b0;
   logic             snoop_match_valid, snoop_match;
   logic [CW-1:0]    snoop_hit_cnt;

   int errors = 0;
   int checks = 0;
   int wcred  = 0;
   logic [7:0] rd_q [$];
   logic [7:0] e [$];

   always #5 clk = ~clk;

   ah_snoop_credit_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_CREDITS(16)) dut (
      .clk(clk), .rstn(rstn),
      .wr_data(wr_data), .wr_valid(wr_valid),
      .wr_credit(wr_credit), .wr_overflow(wr_overflow),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_credit(rd_credit), .rd_credit_err(rd_credit_err),
      .snoop_data(snoop_data), .snoop_mask(snoop_mask),
      .snoop_valid(snoop_valid), .snoop_kill(snoop_kill),
      .snoop_match_valid(snoop_match_valid), .snoop_match(snoop_match),
      .snoop_hit_cnt(snoop_hit_cnt)
   );

   // Collect the downstream stream and the upstream credit returns.
   always @(negedge clk) begin
      if (rstn) begin
         if (rd_valid)  rd_q.push_back(rd_data);
         if (wr_credit) wcred++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_seq(input string tag, input logic [7:0] ex [$]);
      chk({tag, "_len"}, rd_q.size(), ex.size());
      for (int i = 0; i < ex.size(); i++)
         if (i < rd_q.size()) chk(tag, rd_q[i], ex[i]);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      wr_valid = 1'b0; rd_credit = 1'b0; snoop_valid = 1'b0; snoop_kill = 1'b0;
      @(negedge clk); rstn = 1'b0;
      @(negedge clk); rstn = 1'b1;
      tick();
      rd_q.delete(); wcred = 0;
   endtask

   task automatic push(input logic [7:0] d);
      wr_valid = 1'b1; wr_data = d;
      tick();
      wr_valid = 1'b0;
   endtask

   // Burn all 16 downstream credits so later entries stay queued.
   task automatic exhaust();
      for (int i = 0; i < 16; i++) push(8'(8'hE0 + i));
      repeat (4) tick();
      rd_q.delete(); wcred = 0;
   endtask

   initial begin
      // 1: reset state, then back-to-back stream 0x11..0x1A
      do_reset();
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_wr_credit", wr_credit, 0);
      chk("rst_wr_overflow", wr_overflow, 0);
      chk("rst_credit_err", rd_credit_err, 0);
      chk("rst_snoop", {snoop_match_valid, snoop_match, 4'(snoop_hit_cnt)}, 0);
      chk("rst_cred", dut.cred_q, 16);
      wr_valid = 1'b1; wr_data = 8'h11;
      tick();
      chk("t1_lat_n1", rd_valid, 0);
      wr_data = 8'h12;
      tick();
      chk("t1_lat_n2_valid", rd_valid, 1);
      chk("t1_lat_n2_data", rd_data, 8'h11);
      for (int i = 3; i <= 10; i++) begin
         wr_data = 8'(8'h10 + i);
         tick();
      end
      wr_valid = 1'b0;
      repeat (4) tick();
      e = {};
      for (int i = 1; i <= 10; i++) e.push_back(8'(8'h10 + i));
      chk_seq("t1_stream", e);
      chk("t1_wr_credits", wcred, 10);
      chk("t1_cred_end", dut.cred_q, 6);

      // 2: 17 pushes with 16 credits, then one credit releases the 17th
      do_reset();
      for (int i = 0; i < 17; i++) push(8'(8'h20 + i));
      repeat (5) tick();
      chk("t2_sent", rd_q.size(), 16);
      chk("t2_count", dut.count_q, 1);
      chk("t2_no_ovf", wr_overflow, 0);
      rd_credit = 1'b1;
      tick();
      rd_credit = 1'b0;
      chk("t2_t1_valid", rd_valid, 0);
      tick();
      chk("t2_t2_valid", rd_valid, 1);
      chk("t2_t2_data", rd_data, 8'h30);
      tick();

      // 3: full FIFO drops the 11th push; push alongside a pop is accepted
      for (int i = 0; i < 10; i++) push(8'(8'h40 + i));
      chk("t3_full_no_ovf", wr_overflow, 0);
      chk("t3_full_count", dut.count_q, 10);
      push(8'h4A);
      chk("t3_ovf", wr_overflow, 1);
      chk("t3_ovf_count", dut.count_q, 10);
      rd_credit = 1'b1;
      tick();
      rd_credit = 1'b0;
      rd_q.delete();
      push(8'h4B);
      chk("t3_pop_push_count", dut.count_q, 10);
      chk("t3_pop_data", rd_data, 8'h40);
      rd_credit = 1'b1;
      repeat (10) tick();
      rd_credit = 1'b0;
      repeat (4) tick();
      e = {};
      for (int i = 0; i < 10; i++) e.push_back(8'(8'h40 + i));
      e.push_back(8'h4B);
      chk_seq("t3_drain", e);
      chk("t3_ovf_sticky", wr_overflow, 1);

      // 4: masked snoop counts over 0x05,0x15,0x05
      do_reset();
      exhaust();
      push(8'h05); push(8'h15); push(8'h05);
      snoop_valid = 1'b1; snoop_data = 8'h05; snoop_mask = 8'hFF;
      tick();
      chk("t4_ff_valid", snoop_match_valid, 1);
      chk("t4_ff_match", snoop_match, 1);
      chk("t4_ff_cnt", snoop_hit_cnt, 2);
      snoop_mask = 8'h0F;
      tick();
      chk("t4_0f_cnt", snoop_hit_cnt, 3);
      snoop_data = 8'hAA; snoop_mask = 8'h00;
      tick();
      chk("t4_m0_cnt", snoop_hit_cnt, 3);
      snoop_valid = 1'b0;
      tick();
      chk("t4_idle", {snoop_match_valid, snoop_match, 4'(snoop_hit_cnt)}, 0);
      rd_credit = 1'b1;
      tick();
      rd_credit = 1'b0;
      snoop_valid = 1'b1; snoop_data = 8'h05; snoop_mask = 8'hFF;
      wr_valid = 1'b1; wr_data = 8'h05;
      tick();
      snoop_valid = 1'b0; wr_valid = 1'b0;
      chk("t4_popcount_cnt", snoop_hit_cnt, 2);
      chk("t4_pop_valid", rd_valid, 1);
      chk("t4_pop_data", rd_data, 8'h05);
      rd_credit = 1'b1;
      repeat (3) tick();
      rd_credit = 1'b0;
      repeat (4) tick();
      snoop_valid = 1'b1;
      tick();
      snoop_valid = 1'b0;
      chk("t4_empty_valid", snoop_match_valid, 1);
      chk("t4_empty_match", snoop_match, 0);
      chk("t4_empty_cnt", snoop_hit_cnt, 0);

      // 5: snoop-kill of 0x15 (ignored when the feature is compiled out)
      do_reset();
      exhaust();
      push(8'h05); push(8'h15); push(8'h05);
      snoop_valid = 1'b1; snoop_kill = 1'b1; snoop_data = 8'h15; snoop_mask = 8'hFF;
      tick();
      snoop_kill = 1'b0;
      chk("t5_kill_cnt", snoop_hit_cnt, 1);
      tick();
      snoop_valid = 1'b0;
      chk("t5_after_kill_cnt", snoop_hit_cnt, KILL ? 0 : 1);
      rd_q.delete(); wcred = 0;
      rd_credit = 1'b1;
      repeat (3) tick();
      rd_credit = 1'b0;
      repeat (5) tick();
      e = {};
      e.push_back(8'h05);
      if (!KILL) e.push_back(8'h15);
      e.push_back(8'h05);
      chk_seq("t5_out", e);
      chk("t5_wr_credits", wcred, 3);

      // 6: asynchronous reset mid-stream with 5 queued
      do_reset();
      exhaust();
      for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
      #2 rstn = 1'b0;
      #1;
      chk("t6_rd_data", rd_data, 0);
      chk("t6_rd_valid", rd_valid, 0);
      chk("t6_count", dut.count_q, 0);
      chk("t6_cred", dut.cred_q, 16);
      @(negedge clk); rstn = 1'b1;
      tick();
      rd_q.delete(); wcred = 0;
      for (int i = 0; i < 10; i++) push(8'(8'h70 + i));
      repeat (4) tick();
      chk("t6_no_ovf", wr_overflow, 0);
      chk("t6_sent", rd_q.size(), 10);
      chk("t6_wr_credits", wcred, 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
